uart_tx_streamer: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_streamer_byte_fifo.sv | 78 +++++++
 rtl/uart_tx_streamer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic data_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_streamer_byte_fifo.sv
// First-word fall-through byte FIFO; full/empty are flops updated from the next count.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]     CNT_ZERO = (PW+1)'(0);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]   PTR_ZERO = PW'(0);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic [PW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    always_comb begin
        push_ok_s    = push && !full_r;
        pop_ok_s     = pop && !empty_r;
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/uart_tx_streamer.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add a parity bit
// (PARITY_ODD selects odd parity).
module uart_tx_streamer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
`ifdef UART_TX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int              BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int              TW         = $clog2(BIT_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0]   TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [2:0]      INDEX_LAST = 3'(DATA_BITS - 1);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx_streamer: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    tx_state_t              state_r, next_state_s;
    logic [TW-1:0]          timer_r, timer_next_s;
    logic [2:0]             index_r, index_next_s;
    logic [DATA_BITS-1:0]   shift_r, shift_next_s;
    logic                   tx_r, tx_s, busy_r, pop_s, bit_done_s;
    logic [DATA_BITS-1:0]   fifo_dout_s;
    logic                   fifo_full_s, fifo_empty_s;
`ifdef UART_TX_PARITY_EN
    logic                   parity_r;
`endif

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (in_data),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // Next-state, bit timing and line level for the current state.
    always_comb begin
        next_state_s = state_r;
        timer_next_s = timer_r;
        index_next_s = index_r;
        shift_next_s = shift_r;
        pop_s        = 1'b0;
        tx_s         = IDLE_LEVEL;
        bit_done_s   = (timer_r == TIMER_LAST);
        case (state_r)
            ST_IDLE: begin
                tx_s = IDLE_LEVEL;
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_dout_s;
                    timer_next_s = TIMER_ZERO;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (bit_done_s) begin
                    timer_next_s = TIMER_ZERO;
                    index_next_s = 3'd0;
                    next_state_s = ST_DATA;
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                end
            end
            ST_DATA: begin
                tx_s = shift_r[0];
                if (bit_done_s) begin
                    timer_next_s = TIMER_ZERO;
                    shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (index_r == INDEX_LAST) begin
                        index_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        next_state_s = ST_PARITY;
`else
                        next_state_s = ST_STOP;
`endif
                    end else begin
                        index_next_s = index_r + 3'd1;
                    end
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_s = parity_r;
                if (bit_done_s) begin
                    timer_next_s = TIMER_ZERO;
                    next_state_s = ST_STOP;
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                end
            end
`endif
            ST_STOP: begin
                tx_s = IDLE_LEVEL;
                if (bit_done_s) begin
                    timer_next_s = TIMER_ZERO;
                    // Chain straight into the next start bit so frames have no idle gap.
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = fifo_dout_s;
                        next_state_s = ST_START;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                timer_next_s = TIMER_ZERO;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, shifter and the registered line/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= TIMER_ZERO;
            index_r <= 3'd0;
            shift_r <= {DATA_BITS{1'b0}};
            tx_r    <= IDLE_LEVEL;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            timer_r <= timer_next_s;
            index_r <= index_next_s;
            shift_r <= shift_next_s;
            tx_r    <= tx_s;
            busy_r  <= (state_r != ST_IDLE) || !fifo_empty_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte being loaded, held for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if (pop_s) begin
            parity_r <= data_parity(fifo_dout_s) ^ PARITY_ODD;
        end
    end
`endif

    assign in_ready = ~fifo_full_s;
    assign tx       = tx_r;
    assign busy     = busy_r;

endmodule
